// File: rtl/adder_share_arbiter_if.sv
// Request/response bundle for the shared add/subtract datapath: one valid/ready
// request lane per requester plus a single tagged response channel.
interface adder_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 17,
  parameter int ID_W    = 2
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_op1;
  logic [NUM_REQ*WIDTH-1:0] req_op2;
  logic [NUM_REQ-1:0]       req_sub;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_sum;
  logic                     rsp_overflow;

  // Requesters and the result consumer.
  modport master (
    output req_valid, req_op1, req_op2, req_sub, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_overflow
  );

  // The arbiter.
  modport slave (
    input  req_valid, req_op1, req_op2, req_sub, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_overflow
  );

endinterface

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one ripple add/subtract datapath among NUM_REQ
// requesters; one operation in flight, registered response held under backpressure.
module adder_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 17,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  adder_share_arbiter_if.slave  bus,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q, state_n;
  logic [ID_W-1:0]    ptr_q, ptr_n;
  logic [ID_W-1:0]    winner, hi_idx, lo_idx;
  logic               hi_found, lo_found, found, grant;
  logic [NUM_REQ-1:0] req_ready;

  logic [WIDTH-1:0]   sel_op1, sel_op2;
  logic               sel_sub;
  logic [WIDTH-1:0]   op1_q, op2_q;
  logic               sub_q;
  logic [ID_W-1:0]    id_q;

  logic [WIDTH-1:0]   b_op, sum;
  logic [WIDTH:0]     carry;
  logic               ovf;

  logic [ID_W-1:0]    rsp_id_q;
  logic [WIDTH-1:0]   rsp_sum_q;
  logic               rsp_ovf_q;

  // Round-robin search: the lowest valid index at or above the pointer wins,
  // otherwise the lowest valid index overall (wrap-around). Scanning downward
  // leaves the lowest match in each candidate.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        lo_found = 1'b1;
        lo_idx   = ID_W'(i);
        if (ID_W'(i) >= ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = ID_W'(i);
        end
      end
    end
    found  = lo_found;
    winner = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    sel_op1 = '0;
    sel_op2 = '0;
    sel_sub = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        sel_op1 = bus.req_op1[i*WIDTH +: WIDTH];
        sel_op2 = bus.req_op2[i*WIDTH +: WIDTH];
        sel_sub = bus.req_sub[i];
      end
    end
  end

  // Next-state and grant logic; only IDLE may grant.
  always_comb begin
    state_n   = state_q;
    ptr_n     = ptr_q;
    grant     = 1'b0;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant             = 1'b1;
          req_ready[winner] = 1'b1;
          ptr_n             = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
          state_n           = EXEC;
        end
      end
      EXEC:    state_n = RESP;
      RESP:    if (bus.rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Ripple datapath: subtraction inverts op2 and injects a carry-in of one.
  // carry[k+1] is the carry out of bit k.
  always_comb begin
    b_op     = op2_q ^ {WIDTH{sub_q}};
    carry    = '0;
    carry[0] = sub_q;
    sum      = '0;
    for (int k = 0; k < WIDTH; k++) begin
      sum[k]     = op1_q[k] ^ b_op[k] ^ carry[k];
      carry[k+1] = (op1_q[k] & b_op[k]) | (carry[k] & (op1_q[k] ^ b_op[k]));
    end
    ovf = sub_q ? (carry[WIDTH-1] ^ carry[WIDTH]) : carry[WIDTH];
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      rsp_id_q  <= '0;
      rsp_sum_q <= '0;
      rsp_ovf_q <= 1'b0;
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
      if (state_q == EXEC) begin
        rsp_id_q  <= id_q;
        rsp_sum_q <= sum;
        rsp_ovf_q <= ovf;
      end
    end
  end

  // NOTE: operand latches carry no reset; they are always written by a grant
  // before the EXEC cycle reads them.
  always_ff @(posedge clk) begin
    if (grant) begin
      op1_q <= sel_op1;
      op2_q <= sel_op2;
      sub_q <= sel_sub;
      id_q  <= winner;
    end
  end

  assign bus.req_ready    = req_ready;
  assign bus.rsp_valid    = (state_q == RESP);
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_sum      = rsp_sum_q;
  assign bus.rsp_overflow = rsp_ovf_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: add/sub results, round-robin order,
// backpressure hold and reset in EXEC and RESP, against hand-computed values.
module tb_adder_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 17;
  localparam int ID_W    = 2;

  logic clk;
  logic rst;
  logic busy;

  int n_vec;
  int n_err;

  adder_share_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) bus ();

  adder_share_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic s);
    bus.req_op1[i*WIDTH +: WIDTH] = a;
    bus.req_op2[i*WIDTH +: WIDTH] = b;
    bus.req_sub[i]                = s;
    bus.req_valid[i]              = 1'b1;
  endtask

  // Called in IDLE with requests already driven and rsp_ready=1: checks the grant,
  // the EXEC cycle, the response two cycles after the grant, and the return to IDLE.
  task automatic run_op(input int i, input logic [NUM_REQ-1:0] exp_ready, input int exp_id,
                        input logic [WIDTH-1:0] exp_sum, input logic exp_ovf, input string tag);
    #1;
    check({tag, ".grant"}, 32'(bus.req_ready), 32'(exp_ready));
    tick();
    bus.req_valid[i] = 1'b0;
    #1;
    check({tag, ".exec_ready"}, 32'(bus.req_ready), 32'd0);
    check({tag, ".exec_busy"}, 32'(busy), 32'd1);
    check({tag, ".exec_valid"}, 32'(bus.rsp_valid), 32'd0);
    tick();
    check({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, ".rsp_id"}, 32'(bus.rsp_id), 32'(exp_id));
    check({tag, ".rsp_sum"}, 32'(bus.rsp_sum), 32'(exp_sum));
    check({tag, ".rsp_ovf"}, 32'(bus.rsp_overflow), 32'(exp_ovf));
    tick();
    check({tag, ".idle_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, ".idle_busy"}, 32'(busy), 32'd0);
  endtask

  int                 gr_cyc [5];
  logic [NUM_REQ-1:0] gr_vec [5];
  int                 n_gr;

  initial begin
    n_vec         = 0;
    n_err         = 0;
    n_gr          = 0;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_op1   = '0;
    bus.req_op2   = '0;
    bus.req_sub   = '0;
    bus.rsp_ready = 1'b1;

    // Reset state.
    tick();
    tick();
    check("rst.req_ready", 32'(bus.req_ready), 32'd0);
    check("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst.rsp_id", 32'(bus.rsp_id), 32'd0);
    check("rst.rsp_sum", 32'(bus.rsp_sum), 32'd0);
    check("rst.rsp_ovf", 32'(bus.rsp_overflow), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Round robin from reset: all valid, grants 0,1,2,3,0 spaced 3 cycles apart.
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 17'(i), 17'd1, 1'b0);
    for (int cyc = 0; cyc < 15; cyc++) begin
      #1;
      if (bus.req_ready != '0 && n_gr < 5) begin
        gr_cyc[n_gr] = cyc;
        gr_vec[n_gr] = bus.req_ready;
        n_gr++;
      end
      tick();
    end
    bus.req_valid = '0;
    check("rr.count", 32'(n_gr), 32'd5);
    for (int g = 0; g < n_gr; g++) begin
      check($sformatf("rr.grant%0d", g), 32'(gr_vec[g]), 32'(1 << (g % NUM_REQ)));
      check($sformatf("rr.cycle%0d", g), 32'(gr_cyc[g]), 32'(3 * g));
    end

    // Pointer now 1; a lone req0 wraps around and wins.
    set_req(0, 17'h0FFFF, 17'h00001, 1'b0);
    run_op(0, 4'b0001, 0, 17'h10000, 1'b0, "add");
    set_req(2, 17'h1FFFF, 17'h00001, 1'b0);
    run_op(2, 4'b0100, 2, 17'h00000, 1'b1, "add_wrap");
    set_req(1, 17'h00005, 17'h00003, 1'b1);
    run_op(1, 4'b0010, 1, 17'h00002, 1'b0, "sub");

    // Pointer now 2: with req1 and req3 valid, req3 first, then req1.
    set_req(1, 17'h0FFFF, 17'h1FFFF, 1'b1);
    set_req(3, 17'h00010, 17'h00020, 1'b0);
    run_op(3, 4'b1000, 3, 17'h00030, 1'b0, "rr13_a");
    run_op(1, 4'b0010, 1, 17'h10000, 1'b1, "rr13_b");

    // Backpressure: req2 result held for 5 cycles while req0 waits.
    bus.rsp_ready = 1'b0;
    set_req(2, 17'h12345, 17'h00001, 1'b0);
    #1;
    check("bp.grant2", 32'(bus.req_ready), 32'b0100);
    tick();
    bus.req_valid[2] = 1'b0;
    set_req(0, 17'h00100, 17'h00001, 1'b1);
    #1;
    check("bp.exec_ready", 32'(bus.req_ready), 32'd0);
    tick();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp.valid%0d", c), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("bp.sum%0d", c), 32'(bus.rsp_sum), 32'h12346);
      check($sformatf("bp.id%0d", c), 32'(bus.rsp_id), 32'd2);
      check($sformatf("bp.ovf%0d", c), 32'(bus.rsp_overflow), 32'd0);
      check($sformatf("bp.ready%0d", c), 32'(bus.req_ready), 32'd0);
      check($sformatf("bp.busy%0d", c), 32'(busy), 32'd1);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp.release_ready", 32'(bus.req_ready), 32'd0);
    tick();
    check("bp.idle_busy", 32'(busy), 32'd0);
    run_op(0, 4'b0001, 0, 17'h000FF, 1'b0, "bp_req0");

    // Reset during EXEC (pointer is 1 before, 2 after the req1 grant).
    set_req(1, 17'h00001, 17'h00001, 1'b0);
    #1;
    check("rx.grant1", 32'(bus.req_ready), 32'b0010);
    tick();
    bus.req_valid[1] = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rx.valid", 32'(bus.rsp_valid), 32'd0);
    check("rx.busy", 32'(busy), 32'd0);
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 17'(i), 17'd2, 1'b0);
    #1;
    check("rx.grant0", 32'(bus.req_ready), 32'b0001);

    // Reset during RESP, with rsp_ready high in the same cycle.
    tick();
    bus.req_valid = '0;
    tick();
    check("rr_resp.valid_before", 32'(bus.rsp_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rr_resp.valid", 32'(bus.rsp_valid), 32'd0);
    check("rr_resp.busy", 32'(busy), 32'd0);
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 17'(i), 17'd3, 1'b0);
    #1;
    check("rr_resp.grant0", 32'(bus.req_ready), 32'b0001);
    bus.req_valid = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
